// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I-subset control FSM with retired-instruction counter.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap illegal instructions in ERROR instead of retiring them as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [3:0]       ALUctl,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ERROR = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  state_t state_q, state_d, dec_next, bad_next;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0] r_ctl, i_ctl;
  logic r_ok, i_ok, retire;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign bad_next = ERROR;
  assign illegal  = (state_q == ERROR);
`else
  assign bad_next = FETCH;
  assign illegal  = 1'b0;
`endif
  always_comb begin
    r_ok  = 1'b1;
    r_ctl = 4'b0010;
    case ({funct3, funct7b5})
      4'b0000: r_ctl = 4'b0010;
      4'b0001: r_ctl = 4'b0110;
      4'b1110: r_ctl = 4'b0000;
      4'b1100: r_ctl = 4'b0001;
      4'b0100: r_ctl = 4'b0111;
      default: r_ok = 1'b0;
    endcase
    i_ok  = 1'b1;
    i_ctl = 4'b0010;
    case (funct3)
      3'b000:  i_ctl = 4'b0010;
      3'b111:  i_ctl = 4'b0000;
      3'b110:  i_ctl = 4'b0001;
      3'b010:  i_ctl = 4'b0111;
      default: i_ok = 1'b0;
    endcase
  end
  // Funct legality is resolved here so EXECR/EXECI only ever see legal codes.
  assign dec_next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    (opcode == OP_R)                     ? (r_ok ? EXECR : bad_next) :
                    (opcode == OP_I)                     ? (i_ok ? EXECI : bad_next) :
                    (opcode == OP_B && funct3 == 3'b000) ? BEQ :
                    (opcode == OP_JAL)                   ? JAL : bad_next;
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ALUctl     = 4'b0010;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = dec_next;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        ALUctl    = r_ctl;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALUctl    = i_ctl;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        ALUctl    = 4'b0110;
        pc_write  = zero;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      ERROR:   state_d = ERROR;
      default: state_d = FETCH;
    endcase
  end
  // Any arrival at FETCH from a later phase ends an instruction (incl. a NOP'd illegal one).
  assign retire    = (state_d == FETCH) && (state_q != FETCH);
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  assign state   = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; instruction-level phase model feeds per-cycle expectations.
module tb_multicycle_ctrl;
  localparam int CW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] ALUctl, state;
  logic [CW-1:0] retired;
  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .ALUctl(ALUctl), .illegal(illegal), .state(state), .retired(retired)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  logic [20+CW-1:0] q[$];
  logic [CW-1:0] m_ret = '0;
  bit rnd_rst = 0;
  int tests = 0, fails = 0, cyc = 0;
  function automatic int r_alu(input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return f7 ? 6 : 2;
    if (f7) return -1;
    if (f3 == 3'b111) return 0;
    if (f3 == 3'b110) return 1;
    if (f3 == 3'b010) return 7;
    return -1;
  endfunction
  function automatic int i_alu(input logic [2:0] f3);
    return (f3 == 3'b000) ? 2 : (f3 == 3'b111) ? 0 : (f3 == 3'b110) ? 1 : (f3 == 3'b010) ? 7 : -1;
  endfunction
  function automatic logic [20+CW-1:0] exp_vec(input logic [3:0] st, input logic mr, input logic z,
                                               input logic [3:0] alu, input logic [CW-1:0] ret);
    logic pw, iw, ad, mw, rw, il;
    logic [1:0] a, b, rs;
    logic [3:0] c;
    {pw, iw, ad, mw, rw, il} = '0;
    {a, b, rs} = '0;
    c = 4'b0010;
    case (st)
      4'd0: begin pw = mr; iw = mr; b = 2'd2; rs = 2'd2; end
      4'd1: begin a = 2'd1; b = 2'd1; end
      4'd2: begin a = 2'd2; b = 2'd1; end
      4'd3: ad = 1'b1;
      4'd4: begin rs = 2'd1; rw = 1'b1; end
      4'd5: begin ad = 1'b1; mw = 1'b1; end
      4'd6: begin a = 2'd2; c = alu; end
      4'd7: begin a = 2'd2; b = 2'd1; c = alu; end
      4'd8: rw = 1'b1;
      4'd9: begin a = 2'd2; c = 4'b0110; pw = z; end
      4'd10: begin a = 2'd1; b = 2'd2; pw = 1'b1; end
      4'd11: il = 1'b1;
      default: ;
    endcase
    return {st, pw, iw, ad, mw, rw, a, b, rs, c, il, ret};
  endfunction
  task automatic step(input logic [3:0] st, input logic mr, input logic z, input logic [3:0] alu,
                      input bit frc, inout bit ab);
    bit r;
    r = frc || (rnd_rst && $urandom_range(0, 59) == 0);
    mem_ready = mr;
    zero = z;
    rst = r;
    q.push_back(exp_vec(st, mr, z, alu, m_ret));
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (r) begin
      m_ret = '0;
      ab = 1;
    end
  endtask
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int fw,
                           input int mw, input logic z, input bit rst_mem);
    int ph[$];
    int rc, ic;
    logic [3:0] alu;
    bit ab;
    ab = 0;
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
    rc = r_alu(f3, f7);
    ic = i_alu(f3);
    alu = 4'b0010;
    if (op == LW) ph = {2, 3, 4};
    else if (op == SW) ph = {2, 5};
    else if (op == RT && rc >= 0) begin ph = {6, 8}; alu = 4'(rc); end
    else if (op == IT && ic >= 0) begin ph = {7, 8}; alu = 4'(ic); end
    else if (op == BR && f3 == 3'b000) ph = {9};
    else if (op == JL) ph = {10, 8};
    for (int i = 0; i < fw && !ab; i++) step(4'd0, 1'b0, z, alu, 0, ab);
    if (!ab) step(4'd0, 1'b1, z, alu, 0, ab);
    if (!ab) step(4'd1, 1'($urandom_range(0, 1)), z, alu, 0, ab);
    if (ab) return;
    if (ph.size() == 0) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      for (int k = 0; k < 3 && !ab; k++) step(4'd11, 1'($urandom_range(0, 1)), z, alu, 0, ab);
      if (!ab) step(4'd11, 1'b1, z, alu, 1, ab);
`else
      m_ret = m_ret + 1'b1;
`endif
      return;
    end
    foreach (ph[i]) begin
      if (ph[i] == 3 || ph[i] == 5) begin
        for (int j = 0; j < mw && !ab; j++) step(4'(ph[i]), 1'b0, z, alu, rst_mem && j == mw - 1, ab);
        if (!ab) step(4'(ph[i]), 1'b1, z, alu, 0, ab);
      end else step(4'(ph[i]), 1'($urandom_range(0, 1)), z, alu, 0, ab);
      if (ab) return;
    end
    m_ret = m_ret + 1'b1;
  endtask
  always @(negedge clk) begin
    logic [20+CW-1:0] e, g;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {state, pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, alu_src_b,
           result_src, ALUctl, illegal, retired};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d exp_state=%0d got=%h exp=%h", cyc, e[20+CW-1 -: 4], g, e);
      end
    end
  end
  initial begin
    logic [6:0] ops[7];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{LW, SW, RT, IT, BR, JL, 7'b1111111};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(RT, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    run_instr(RT, 3'b000, 1'b1, 0, 0, 1'b0, 0);
    run_instr(IT, 3'b010, 1'b1, 0, 0, 1'b0, 0);
    run_instr(LW, 3'b010, 1'b0, 2, 3, 1'b0, 0);
    run_instr(BR, 3'b000, 1'b0, 0, 0, 1'b1, 0);
    run_instr(BR, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    run_instr(JL, 3'b000, 1'b0, 1, 0, 1'b0, 0);
    run_instr(SW, 3'b010, 1'b0, 0, 3, 1'b0, 1);
    run_instr(SW, 3'b010, 1'b0, 0, 1, 1'b0, 0);
    run_instr(RT, 3'b001, 1'b0, 0, 0, 1'b0, 0);
    run_instr(IT, 3'b011, 1'b0, 0, 0, 1'b0, 0);
    rnd_rst = 1;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      f3 = ($urandom_range(0, 1) == 0) ? 3'(2 * $urandom_range(0, 1)) : 3'($urandom);
      run_instr(op, f3, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0);
    end
    rnd_rst = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
